// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-write scoreboard plus forwarding select for an in-order pipeline.
// Each architectural register r (1..NUM_REGS-1) has a countdown of bubbles that a dependent
// instruction still needs. Register 0 never carries pending state.
// Optional macro HAZARD_PERF_EN enables the saturating stall_cycles counter. When the macro
// is undefined, stall_cycles is tied to 0 and no counter flops are built.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_*                  ID instruction destination write (valid, wen, rd, latency)
//   id_rs1/2, id_rs1/2_used  ID source registers and their use flags
//   flush                    pipeline flush; clears all pending state
//   ex_rs1/2, ex_rs1/2_reg   EX operand registers sourced from the register file
//   exmem_*/memwb_*          downstream writeback destinations
//   fwd_a, fwd_b             operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall, pc_we, ifid_we, ctrl_bubble, busy, stall_cycles
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LAT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              flush,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              ex_rs1_reg,
  input  logic              ex_rs2_reg,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              exmem_wen,
  input  logic              memwb_wen,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ctrl_bubble,
  output logic              busy,
  output logic [31:0]       stall_cycles
);

  // Array covers the full address space so any address indexes safely; entries beyond
  // NUM_REGS-1 and entry 0 are held at zero.
  localparam int unsigned Depth = 2 ** REG_AW;

  logic [LAT_W-1:0] cnt [Depth];
  logic             srcHz;
  logic             wawHz;
  logic             iss;
  logic             anyPending;

  // Hazard detection against the registered pending counters.
  always_comb begin
    srcHz = 1'b0;
    wawHz = 1'b0;
    if (id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0)) srcHz = 1'b1;
    if (id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0)) srcHz = 1'b1;
    if (issue_valid && issue_wen && (issue_rd != '0) && (cnt[issue_rd] > issue_lat)) wawHz = 1'b1;
  end

  assign stall       = issue_valid & (srcHz | wawHz) & ~flush;
  assign pc_we       = ~stall;
  assign ifid_we     = ~stall;
  assign ctrl_bubble = stall;

  // A zero-latency producer needs no bubbles, so it does not occupy the scoreboard.
  assign iss = issue_valid & issue_wen & (issue_rd != '0) & (issue_lat != '0) & ~stall & ~flush;

  // Pending counters: flush clears, issue loads, otherwise count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < Depth; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < Depth; r++) begin
        if ((r == 0) || (r >= NUM_REGS)) begin
          cnt[r] <= '0;
        end else if (flush) begin
          cnt[r] <= '0;
        end else if (iss && (issue_rd == REG_AW'(r))) begin
          cnt[r] <= issue_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  // busy reflects any outstanding pending write.
  always_comb begin
    anyPending = 1'b0;
    for (int unsigned r = 0; r < Depth; r++) begin
      if (cnt[r] != '0) anyPending = 1'b1;
    end
  end

  assign busy = anyPending;

  // Forwarding select; EX/MEM is younger and wins, x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_rs1_reg && (ex_rs1 != '0)) begin
      if (exmem_wen && (exmem_rd == ex_rs1))      fwd_a = 2'b01;
      else if (memwb_wen && (memwb_rd == ex_rs1)) fwd_a = 2'b10;
    end
    if (ex_rs2_reg && (ex_rs2 != '0)) begin
      if (exmem_wen && (exmem_rd == ex_rs2))      fwd_b = 2'b01;
      else if (memwb_wen && (memwb_rd == ex_rs2)) fwd_b = 2'b10;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCycles;

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles <= '0;
    end else if (stall && (stallCycles != 32'hFFFF_FFFF)) begin
      stallCycles <= stallCycles + 32'd1;
    end
  end

  assign stall_cycles = stallCycles;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
